// File: rtl/fft_bitrev_reorder.sv
// Output reorder buffer for the streaming FFT: takes a bit-reversed-order frame
// and re-emits it in natural order through a ping-pong pair of RAM banks.
module fft_bitrev_reorder #(
    parameter int unsigned LGSIZE = 12,
    parameter int unsigned WIDTH  = 34
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clk_enable,
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_sync,
    output logic [WIDTH-1:0] o_out,
    output logic             o_sync
);

    localparam int unsigned N     = 2 ** LGSIZE;
    localparam int unsigned DEPTH = 2 * N;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LGSIZE-1:0] wcnt;
    logic              wbank;
    logic              primed;
    logic              wr_en_c;
    logic [LGSIZE:0]   waddr_c;
    logic [LGSIZE:0]   raddr_c;
    logic [WIDTH-1:0]  mem [DEPTH];

    function automatic logic [LGSIZE-1:0] bitrev(input logic [LGSIZE-1:0] v);
        logic [LGSIZE-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LGSIZE); i++) begin
            r[i] = v[int'(LGSIZE) - 1 - i];
        end
        return r;
    endfunction

    // Framing lock: wait for the first sync, then run until reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_WAIT;
        end else if (i_clk_enable) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT: if (i_sync) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_WAIT;
        endcase
    end

    always_comb begin
        wr_en_c = 1'b0;
        case (state)
            ST_WAIT: wr_en_c = i_clk_enable && i_sync && !i_reset;
            ST_RUN:  wr_en_c = i_clk_enable && !i_reset;
            default: wr_en_c = 1'b0;
        endcase
    end

    assign waddr_c = {wbank, wcnt};
    assign raddr_c = {~wbank, bitrev(wcnt)};

    // Write counter; bank flips on the write of the last sample of a frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wcnt   <= '0;
            wbank  <= 1'b0;
            primed <= 1'b0;
        end else if (wr_en_c) begin
            wcnt <= wcnt + LGSIZE'(1);
            if (&wcnt) begin
                wbank  <= ~wbank;
                primed <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en_c) begin
            mem[waddr_c] <= i_in;
        end
    end

    // Read side always addresses the bank not being written.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_out  <= '0;
            o_sync <= 1'b0;
        end else if (i_clk_enable) begin
            if (primed) begin
                o_out  <= mem[raddr_c];
                o_sync <= (wcnt == '0);
            end else begin
                o_out  <= '0;
                o_sync <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: a small (N=8) and a full-size (N=4096)
// instance, each checked cycle by cycle against a frame-level reference model.
module tb_fft_bitrev_reorder;

    localparam int unsigned W = 34;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_s = 1'b1, en_s = 1'b0, sync_s = 1'b0;
    logic [W-1:0] in_s = '0;
    logic [W-1:0] out_s;
    logic         osync_s;

    logic         rst_b = 1'b1, en_b = 1'b0, sync_b = 1'b0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] out_b;
    logic         osync_b;

    fft_bitrev_reorder #(.LGSIZE(3), .WIDTH(W)) dut_small (
        .i_clk(clk), .i_reset(rst_s), .i_clk_enable(en_s),
        .i_in(in_s), .i_sync(sync_s), .o_out(out_s), .o_sync(osync_s)
    );

    fft_bitrev_reorder #(.LGSIZE(12), .WIDTH(W)) dut_big (
        .i_clk(clk), .i_reset(rst_b), .i_clk_enable(en_b),
        .i_in(in_b), .i_sync(sync_b), .o_out(out_b), .o_sync(osync_b)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         s;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   sel = 1'b0;

    // Frame-level reference: collected frames, replayed in natural order.
    bit           m_locked = 1'b0;
    bit           m_have_prev = 1'b0;
    int           m_pos = 0;
    logic [W-1:0] m_cur  [4096];
    logic [W-1:0] m_prev [4096];
    exp_t         m_last = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int brev(input int v, input int lg);
        int r = 0;
        for (int i = 0; i < lg; i++) r |= ((v >> i) & 1) << (lg - 1 - i);
        return r;
    endfunction

    // Drive one cycle on the selected instance and queue the output expected after its edge.
    task automatic drive(input bit rst, input bit en, input logic [W-1:0] d, input bit s);
        int lg;
        int n;
        @(negedge clk);
        if (sel) begin
            rst_b = rst; en_b = en; in_b = d; sync_b = s;
        end else begin
            rst_s = rst; en_s = en; in_s = d; sync_s = s;
        end
        lg = sel ? 12 : 3;
        n  = 1 << lg;
        if (rst) begin
            m_locked = 1'b0; m_have_prev = 1'b0; m_pos = 0; m_last = '0;
        end else if (en) begin
            if (m_have_prev) begin
                m_last.d = m_prev[brev(m_pos, lg)];
                m_last.s = (m_pos == 0);
            end else begin
                m_last = '0;
            end
            if (m_locked || s) begin
                m_locked = 1'b1;
                m_cur[m_pos] = d;
                m_pos++;
                if (m_pos == n) begin
                    m_pos = 0;
                    m_prev = m_cur;
                    m_have_prev = 1'b1;
                end
            end
        end
        sb_q.push_back(m_last);
    endtask

    task automatic drive_sample(input logic [W-1:0] d, input bit s, input bit gaps);
        if (gaps) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 1) == 0) break;
                drive(1'b0, 1'b0, W'($urandom), 1'($urandom));
            end
        end
        drive(1'b0, 1'b1, d, s);
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (sel) begin
                check("big o_out", 64'(out_b), 64'(e.d));
                check("big o_sync", 64'(osync_b), 64'(e.s));
            end else begin
                check("small o_out", 64'(out_s), 64'(e.d));
                check("small o_sync", 64'(osync_s), 64'(e.s));
            end
        end
    end

    initial begin
        sel = 1'b0;
        drive(1'b1, 1'b1, '0, 1'b0);
        drive(1'b1, 1'b1, '0, 1'b0);

        // Basic reorder: 0..7, 8..15, then a third frame to flush the second.
        for (int i = 0; i < 24; i++) drive_sample(W'(i), i == 0, 1'b0);

        // Pre-sync discard.
        drive(1'b1, 1'b1, '0, 1'b0);
        for (int i = 0; i < 5; i++) drive_sample(W'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) drive_sample(W'(200 + i), i == 0, 1'b0);

        // Enable gaps with junk on the inputs during disabled cycles.
        drive(1'b1, 1'b1, '0, 1'b0);
        for (int i = 0; i < 24; i++) drive_sample(W'(300 + i), i == 0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, W'($urandom), 1'b1);

        // Stray sync on index 3 of the second frame.
        drive(1'b1, 1'b1, '0, 1'b0);
        for (int i = 0; i < 32; i++) drive_sample(W'(400 + i), (i == 0) || (i == 11), 1'b0);

        // Reset at index 5 of the second frame, with sync and enable also high.
        drive(1'b1, 1'b1, '0, 1'b0);
        for (int i = 0; i < 13; i++) drive_sample(W'(500 + i), i == 0, 1'b0);
        drive(1'b1, 1'b1, W'(999), 1'b1);
        for (int i = 0; i < 3; i++) drive_sample(W'(600 + i), 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) drive_sample(W'(700 + i), i == 0, 1'b1);

        // Full-size smoke on the 4096-point instance.
        @(negedge clk);
        @(negedge clk);
        rst_s = 1'b1; en_s = 1'b0;
        sel = 1'b1;
        drive(1'b1, 1'b1, '0, 1'b0);
        for (int i = 0; i < 3 * 4096; i++) drive_sample(W'({$urandom, $urandom}), i == 0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer for the 1-sample-per-clock 4096-point FFT. It receives the bit-reversed-order complex stream leaving the final butterfly stage (`{real, imag}` words plus a frame sync) and re-emits each frame in natural frequency order. It uses a ping-pong double-buffer: one bank is written in arrival order while the other is read with bit-reversed addressing. It sits directly downstream of the last butterfly stage and shares its clock-enable.

## Interface
- `LGSIZE`, 12: log2 of frame length N (N = 2^LGSIZE samples per frame).
- `WIDTH`, 34: sample word width, `{real, imag}` packed; the default matches 2×17-bit last-stage output.

- `i_clk`, input, 1: clock. All logic on rising edge.
- `i_reset`, input, 1: reset. Synchronous, active-high.
- `i_clk_enable`, input, 1: sample strobe. One input sample and one output sample per enabled cycle. All state holds when low.
- `i_in`, input, WIDTH: input sample, bit-reversed order within the frame.
- `i_sync`, input, 1: high with sample index 0 of a frame.
- `o_out`, output, WIDTH: output sample, natural order. Registered.
- `o_sync`, output, 1: high with output sample index 0 of each frame. Registered.

## Operation
- **Storage:** 2×N words, inferred block RAM. The bank select is the MSB of the address.
  - Write port: `{wbank, wcnt}`.
  - Read port: `{~wbank, bitrev(wcnt)}`.
  - `bitrev` reverses the LGSIZE bits.
- **State:**
  - `wcnt`: LGSIZE-bit counter.
  - `wbank`: 1 bit.
  - `waiting`: 1 bit, set by reset.
  - `primed`: 1 bit, cleared by reset.
- **Reset values:** `o_out`=0, `o_sync`=0, `wcnt`=0, `wbank`=0, `waiting`=1, `primed`=0.
- **WAIT state (`waiting`=1):**
  - Enabled samples with `i_sync`=0 are discarded; no write occurs and `wcnt` stays 0.
  - An enabled cycle with `i_sync`=1 writes that sample at address `{wbank,0}`, sets `wcnt`=1 and clears `waiting`.
- **RUN state (`waiting`=0):** each enabled cycle performs the following.
  - Writes `i_in` to `{wbank,wcnt}`.
  - Increments `wcnt`.
  - When `wcnt` wraps from N−1 to 0, toggles `wbank` and sets `primed`=1.
- **Sync after lock:** `i_sync` is ignored, including a sync arriving mid-frame. Framing stays locked to the first sync until reset.
- **Output path:**
  - While `primed`=1, each enabled cycle reads `{~wbank, bitrev(wcnt)}` and registers it to `o_out`.
  - `o_sync` is registered as `primed && wcnt==0`.
  - While `primed`=0, `o_out` and `o_sync` stay 0.
- **No collisions:** read and write always target opposite banks, so read-during-write behaviour is irrelevant.
- **Width:** data passes unchanged. No arithmetic, rounding or truncation.

## Timing
- **Latency:** input sample 0 of frame F (with `i_sync`) is written on enabled cycle t0. Output index 0 of frame F appears on `o_out` with `o_sync`=1 after the edge of enabled cycle t0+N, i.e. N+1 enabled cycles after input sample 0.
- **Output content:** output index n of frame F equals input index bitrev(n) of frame F. Frame F is read out while frame F+1 is being written.
- **Throughput:** one sample per enabled cycle, continuous, no gaps between frames.
- **`o_sync` width:** high for exactly one enabled cycle per frame, every N enabled cycles.
- **`i_clk_enable` low:** counters, banks, flags, `o_out` and `o_sync` all hold their values. Gaps of any length are transparent.
- **Reset mid-frame:** all buffered data is abandoned. Outputs are 0 from the cycle after reset until the first full frame following the next `i_sync` has been collected.
- **Simultaneous events:** `i_reset` overrides `i_clk_enable` and `i_sync`.
- **Wrap:** the bank toggle and the `wcnt` wrap happen in the same cycle as the write of index N−1.

## Test plan
- **Basic reorder:** LGSIZE=3, continuous enable. Drive `i_sync` with sample 0, then values 0..7 and 8..15. Starting 9 enabled cycles after the first sync, `o_out` must be 0,4,2,6,1,5,3,7, with `o_sync`=1 only on the 0. The next frame must be 8,12,10,14,9,13,11,15.
- **Pre-sync discard:** drive 5 samples with `i_sync`=0 after reset, then a synced frame. The discarded samples never appear, and `o_out`/`o_sync` stay 0 until the first synced frame is emitted.
- **Enable gaps:** same stimulus as basic reorder, with random `i_clk_enable` duty (~50%). The output sequence and `o_sync` placement must be identical when counted in enabled cycles, and outputs must hold across disabled cycles.
- **Stray sync:** assert `i_sync` on input index 3 of the second frame. The framing is unchanged and the output still starts with `o_sync` every 8 enabled cycles.
- **Reset mid-operation:** apply reset at input index 5 of frame 2. The next cycle shows `o_out`=0 and `o_sync`=0. After a new sync, the first output appears 9 enabled cycles later.
- **Full-size smoke:** LGSIZE=12, WIDTH=34, three frames of random data. Every output n must equal input bitrev12(n) of the prior frame, with `o_sync` period 4096.
